// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 bus sink.
package hub75_pkg;

  // One pixel as it appears on the bus, MSB first: {r1,g1,b1,r2,g2,b2}.
  typedef struct packed {
    logic r1;
    logic g1;
    logic b1;
    logic r2;
    logic g2;
    logic b2;
  } pixel_t;

  localparam int HUB75_COLS   = 32;
  localparam int HUB75_ADDR_W = 3;

  // Bus bundle carried through the synchronizer: oe, lat, oclk, abc, pixel.
  localparam int HUB75_BUS_W  = 3 + HUB75_ADDR_W + $bits(pixel_t);

endpackage

// File: rtl/hub75_sync.sv
// Synchronizes every HUB75 bus input through one common flop chain so the
// signals stay mutually aligned, then detects shift (oclk rise) and
// latch (lat fall) events on the synchronized copies.
module hub75_sync
  import hub75_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              rgb,
  input  logic [HUB75_ADDR_W-1:0] abc,
  input  logic                    oclk,
  input  logic                    lat,
  input  logic                    oe,
  output logic [5:0]              pixel,
  output logic [HUB75_ADDR_W-1:0] abc_s,
  output logic                    oe_s,
  output logic                    shift,
  output logic                    latch
);

  localparam int OE_BIT   = HUB75_BUS_W - 1;
  localparam int LAT_BIT  = HUB75_BUS_W - 2;
  localparam int OCLK_BIT = HUB75_BUS_W - 3;

  logic [HUB75_BUS_W-1:0] chain [SYNC_STAGES];
  logic [HUB75_BUS_W-1:0] last;
  logic                   oclk_q;
  logic                   lat_q;

  assign last = chain[SYNC_STAGES-1];

  // Shift the whole bus bundle through the chain; remember previous oclk/lat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      oclk_q <= 1'b0;
      lat_q  <= 1'b0;
    end else begin
      chain[0] <= {oe, lat, oclk, abc, rgb};
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      oclk_q <= last[OCLK_BIT];
      lat_q  <= last[LAT_BIT];
    end
  end

  assign pixel = last[5:0];
  assign abc_s = last[OCLK_BIT-1 -: HUB75_ADDR_W];
  assign oe_s  = last[OE_BIT];
  assign shift = last[OCLK_BIT] & ~oclk_q;
  assign latch = ~last[LAT_BIT] & lat_q;

endmodule

// File: rtl/hub75_sink.sv
// HUB75 bus sink: captures shifted pixels into a row buffer and presents each
// latched row on a valid/ready output with length flags and oe on-time.
//
// Handshake: a row is transferred when row_valid && row_ready at a rising clk
// edge; row_valid/row_* are held stable until then unless a newer latch event
// overwrites them, in which case overrun is flagged.
module hub75_sink
  import hub75_pkg::*;
#(
  parameter int COLS        = HUB75_COLS,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W      = $clog2(COLS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    r1,
  input  logic                    g1,
  input  logic                    b1,
  input  logic                    r2,
  input  logic                    g2,
  input  logic                    b2,
  input  logic [HUB75_ADDR_W-1:0] abc,
  input  logic                    oclk,
  input  logic                    lat,
  input  logic                    oe,
  output logic [6*COLS-1:0]       row_data,
  output logic [HUB75_ADDR_W-1:0] row_addr,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [CNT_W-1:0]        col_count,
  output logic                    short_row,
  output logic                    long_row,
  output logic                    overrun,
  input  logic                    clear,
  output logic [15:0]             on_cycles
);

  pixel_t                  pixel;
  logic [5:0]              pixel_bits;
  logic [HUB75_ADDR_W-1:0] abc_s;
  logic                    oe_s;
  logic                    shift;
  logic                    latch;

  logic [6*COLS-1:0] shift_buf, buf_nxt;
  logic [CNT_W-1:0]  count, cnt_nxt;
  logic              excess, exc_nxt;
  logic [15:0]       on_cnt, on_nxt;

  hub75_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .rgb   ({r1, g1, b1, r2, g2, b2}),
    .abc   (abc),
    .oclk  (oclk),
    .lat   (lat),
    .oe    (oe),
    .pixel (pixel_bits),
    .abc_s (abc_s),
    .oe_s  (oe_s),
    .shift (shift),
    .latch (latch)
  );

  assign pixel = pixel_t'(pixel_bits);

  // Next buffer/count/excess including this cycle's shift, so a shift that
  // coincides with a latch lands in the latched row.
  always_comb begin
    buf_nxt = shift_buf;
    cnt_nxt = count;
    exc_nxt = excess;
    if (shift) begin
      if (count < CNT_W'(COLS)) begin
        for (int i = 0; i < COLS; i++) begin
          if (count == CNT_W'(i)) buf_nxt[6*i +: 6] = pixel;
        end
        cnt_nxt = count + CNT_W'(1);
      end else begin
        exc_nxt = 1'b1;
      end
    end
  end

  // Saturating count of cycles with oe high, including the current cycle.
  always_comb begin
    on_nxt = on_cnt;
    if (oe_s && on_cnt != 16'hFFFF) on_nxt = on_cnt + 16'd1;
  end

  // Capture state; a latch empties it so unused slots of the next row read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_buf <= '0;
      count     <= '0;
      excess    <= 1'b0;
      on_cnt    <= '0;
    end else if (latch) begin
      shift_buf <= '0;
      count     <= '0;
      excess    <= 1'b0;
      on_cnt    <= '0;
    end else begin
      shift_buf <= buf_nxt;
      count     <= cnt_nxt;
      excess    <= exc_nxt;
      on_cnt    <= on_nxt;
    end
  end

  // Output row registers, loaded on every latch event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_data  <= '0;
      row_addr  <= '0;
      col_count <= '0;
      short_row <= 1'b0;
      long_row  <= 1'b0;
      on_cycles <= '0;
    end else if (latch) begin
      row_data  <= buf_nxt;
      row_addr  <= abc_s;
      col_count <= cnt_nxt;
      short_row <= (cnt_nxt < CNT_W'(COLS));
      long_row  <= exc_nxt;
      on_cycles <= on_nxt;
    end
  end

  // Output handshake and sticky overrun; setting wins over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (latch) begin
        row_valid <= 1'b1;
      end else if (row_valid && row_ready) begin
        row_valid <= 1'b0;
      end
      if (latch && row_valid && !row_ready) begin
        overrun <= 1'b1;
      end else if (clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hub75_sink.sv
// Directed bench for hub75_sink: stimulus pushes the expected row into a
// queue, a monitor pops and compares at every accepted handshake.
module tb_hub75_sink;

  localparam int COLS = 32;

  typedef struct packed {
    logic [6*COLS-1:0] data;
    logic [2:0]        addr;
    logic [5:0]        cnt;
    logic              sh;
    logic              lg;
    logic              ov;
    logic [15:0]       on;
  } row_t;

  localparam int W = $bits(row_t);

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic r1 = 0, g1 = 0, b1 = 0, r2 = 0, g2 = 0, b2 = 0;
  logic [2:0] abc = '0;
  logic oclk = 0, lat = 0, oe = 0;
  logic row_ready = 1, clear = 0;
  logic [6*COLS-1:0] row_data;
  logic [2:0]  row_addr;
  logic        row_valid;
  logic [5:0]  col_count;
  logic        short_row, long_row, overrun;
  logic [15:0] on_cycles;

  hub75_sink #(.COLS(COLS), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .abc(abc), .oclk(oclk), .lat(lat), .oe(oe),
    .row_data(row_data), .row_addr(row_addr), .row_valid(row_valid),
    .row_ready(row_ready), .col_count(col_count),
    .short_row(short_row), .long_row(long_row),
    .overrun(overrun), .clear(clear), .on_cycles(on_cycles)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [5:0] pix [64];

  task automatic chk(input string nm, input logic [6*COLS-1:0] act, input logic [6*COLS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixel(input logic [5:0] p);
    {r1, g1, b1, r2, g2, b2} = p;
    oclk = 1'b0;
    tick(2);
    oclk = 1'b1;
    tick(2);
    oclk = 1'b0;
  endtask

  task automatic latch_row(input logic [2:0] a);
    abc = a;
    lat = 1'b1;
    tick(2);
    lat = 1'b0;
    tick(6);
  endtask

  // Send pix[0..n-1], optionally pushing the expected row first.
  task automatic run_row(input int n, input logic [2:0] a, input logic [5:0] e_cnt,
                         input logic e_sh, input logic e_lg, input logic e_ov,
                         input logic [15:0] e_on, input bit push);
    row_t e;
    e.data = '0;
    for (int i = 0; i < n && i < COLS; i++) e.data[6*i +: 6] = pix[i];
    e.addr = a;
    e.cnt  = e_cnt;
    e.sh   = e_sh;
    e.lg   = e_lg;
    e.ov   = e_ov;
    e.on   = e_on;
    if (push) exp_q.push_back(e);
    for (int i = 0; i < n; i++) send_pixel(pix[i]);
    latch_row(a);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got row_addr=%0d with no row expected", row_addr);
      end else begin
        row_t e;
        e = exp_q.pop_front();
        chk("row_data", row_data, e.data);
        chk("row_addr", 192'(row_addr), 192'(e.addr));
        chk("col_count", 192'(col_count), 192'(e.cnt));
        chk("short_row", 192'(short_row), 192'(e.sh));
        chk("long_row", 192'(long_row), 192'(e.lg));
        chk("overrun", 192'(overrun), 192'(e.ov));
        chk("on_cycles", 192'(on_cycles), 192'(e.on));
      end
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("reset_row_valid", 192'(row_valid), 192'(0));
    chk("reset_row_data", row_data, '0);
    chk("reset_row_addr", 192'(row_addr), 192'(0));
    chk("reset_col_count", 192'(col_count), 192'(0));
    chk("reset_overrun", 192'(overrun), 192'(0));
    chk("reset_on_cycles", 192'(on_cycles), 192'(0));

    // full row of 6'b100000 at address 5
    for (int i = 0; i < 32; i++) pix[i] = 6'b100000;
    run_row(32, 3'd5, 6'd32, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

    // short row: 10 pixels, remainder must read zero
    for (int i = 0; i < 10; i++) pix[i] = 6'(i + 1);
    run_row(10, 3'd2, 6'd10, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);

    // long row: 40 pixels 0..39, only 0..31 kept
    for (int i = 0; i < 40; i++) pix[i] = 6'(i);
    run_row(40, 3'd7, 6'd32, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1);

    // overrun: two rows latched while nothing is accepted
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) pix[i] = 6'h01;
    run_row(5, 3'd1, 6'd5, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 32; i++) pix[i] = 6'(i) ^ 6'h15;
    run_row(32, 3'd3, 6'd32, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1);
    row_ready = 1'b1;
    tick(3);
    chk("overrun_sticky", 192'(overrun), 192'(1));
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    chk("overrun_cleared", 192'(overrun), 192'(0));

    // oe high for 100 clk cycles before the next row
    oe = 1'b1;
    tick(100);
    oe = 1'b0;
    tick(4);
    for (int i = 0; i < 32; i++) pix[i] = 6'h3F;
    run_row(32, 3'd4, 6'd32, 1'b0, 1'b0, 1'b0, 16'd100, 1'b1);

    // reset mid-row discards the partial pixels
    for (int i = 0; i < 12; i++) send_pixel(6'h11);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 32; i++) pix[i] = 6'(i + 5);
    run_row(32, 3'd6, 6'd32, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

    // drain with a bounded wait
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d rows outstanding expected 0", exp_q.size());
    end
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
